// File: rtl/counter_pkg.sv
// counter_pkg: shared encodings and helpers for the modulo-N counter family
package counter_pkg;

    localparam int ENC_BINARY = 0;
    localparam int ENC_GRAY   = 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // True when the modulus fits the register width and the reset value lies inside the count range
    function automatic bit params_ok(input int width, input int modulus, input int reset_value);
        return width >= 1 && width < 31 && modulus >= 2 && modulus <= (1 << width)
            && reset_value >= 0 && reset_value < modulus;
    endfunction

endpackage

// File: rtl/mod_n_next.sv
// mod_n_next: combinational next-state and wrap detect for a modulo-N up/down counter
module mod_n_next
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 6
) (
    input  logic [WIDTH-1:0] state,
    input  logic             up_down,
    output logic [WIDTH-1:0] next,
    output logic             wrap
);

    logic [WIDTH:0] s;

    // Compare one bit wider than the state so MODULUS = 2**WIDTH needs no special case
    always_comb begin
        s    = {1'b0, state};
        wrap = up_down ? (s == (WIDTH+1)'(MODULUS - 1)) : (s == '0);
        next = up_down ? (wrap ? '0 : WIDTH'(s + 1'b1))
                       : (wrap ? WIDTH'(MODULUS - 1) : WIDTH'(s - 1'b1));
    end

endmodule

// File: rtl/mod_n_counter.sv
// mod_n_counter: parametrised modulo-N up/down counter with load, cascade carry and optional Gray output
module mod_n_counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 6,
    parameter int RESET_VALUE = 5,
    parameter int GRAY_OUT    = ENC_BINARY
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_prev,
    output logic             carry_out,
    output logic             wrapped,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] state, step, load_next;
    logic             wrap, load_ok;

    if (!params_ok(WIDTH, MODULUS, RESET_VALUE)) begin : g_bad_params
        $error("mod_n_counter: illegal WIDTH/MODULUS/RESET_VALUE combination");
    end

    mod_n_next #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_next (
        .state  (state),
        .up_down(up_down),
        .next   (step),
        .wrap   (wrap)
    );

    // Load range check, carry (suppressed by load) and output encoding
    always_comb begin
        load_ok   = {1'b0, load_value} < (WIDTH+1)'(MODULUS);
        load_next = load_ok ? load_value : '0;
        carry_out = enable & ~load & wrap;
        count     = (GRAY_OUT == ENC_GRAY) ? WIDTH'(bin2gray(32'(state))) : state;
    end

    // State register on the falling edge: load beats enable beats hold; pulses last one cycle
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RV;
            count_prev <= RV;
            wrapped    <= 1'b0;
            load_err   <= 1'b0;
        end else if (load) begin
            state      <= load_next;
            count_prev <= (load_next != state) ? state : count_prev;
            wrapped    <= 1'b0;
            load_err   <= ~load_ok;
        end else if (enable) begin
            state      <= step;
            count_prev <= state;
            wrapped    <= wrap;
            load_err   <= 1'b0;
        end else begin
            wrapped    <= 1'b0;
            load_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_n_counter.sv
// tb_mod_n_counter: directed scoreboard bench for mod_n_counter (default, cascade and Gray instances)
module tb_mod_n_counter;

    logic clock = 1'b1;
    always #5 clock = ~clock;

    logic       reset_n, enable, up_down, load;
    logic [3:0] load_value, count, count_prev;
    logic       carry_out, wrapped, load_err;

    logic       c_en;
    logic [3:0] lo_cnt, lo_prev, hi_cnt, hi_prev;
    logic       lo_carry, lo_wr, lo_le, hi_carry, hi_wr, hi_le;

    logic       g_en;
    logic [2:0] g_cnt, g_prev;
    logic       g_carry, g_wr, g_le;

    mod_n_counter dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .count(count), .count_prev(count_prev),
        .carry_out(carry_out), .wrapped(wrapped), .load_err(load_err)
    );

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_lo (
        .clock(clock), .reset_n(reset_n), .enable(c_en), .up_down(1'b1),
        .load(1'b0), .load_value(4'd0), .count(lo_cnt), .count_prev(lo_prev),
        .carry_out(lo_carry), .wrapped(lo_wr), .load_err(lo_le)
    );

    mod_n_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_hi (
        .clock(clock), .reset_n(reset_n), .enable(lo_carry), .up_down(1'b1),
        .load(1'b0), .load_value(4'd0), .count(hi_cnt), .count_prev(hi_prev),
        .carry_out(hi_carry), .wrapped(hi_wr), .load_err(hi_le)
    );

    mod_n_counter #(.WIDTH(3), .MODULUS(8), .RESET_VALUE(0), .GRAY_OUT(1)) u_gray (
        .clock(clock), .reset_n(reset_n), .enable(g_en), .up_down(1'b1),
        .load(1'b0), .load_value(3'd0), .count(g_cnt), .count_prev(g_prev),
        .carry_out(g_carry), .wrapped(g_wr), .load_err(g_le)
    );

    typedef struct {
        string      tag;
        logic [3:0] cnt;
        logic [3:0] prev;
        logic       wr;
        logic       le;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] gq[$];
    int         n_assert = 0;
    int         n_fail = 0;
    int         m_state = 5;
    int         m_prev = 5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One falling edge on the default instance; called and returns just after a rising edge
    task automatic step(input logic en, input logic ud, input logic ld, input logic [3:0] lv, input string tag);
        exp_t e;
        int   nxt;
        logic wr, le, at_edge;
        enable = en; up_down = ud; load = ld; load_value = lv;
        at_edge = ud ? (m_state == 5) : (m_state == 0);
        #1 chk({tag, ".carry"}, carry_out, en & ~ld & at_edge);
        wr = 1'b0; le = 1'b0; nxt = m_state;
        if (ld) begin
            nxt = (lv < 6) ? int'(lv) : 0;
            le  = (lv >= 6);
        end else if (en) begin
            nxt = ud ? ((m_state == 5) ? 0 : m_state + 1) : ((m_state == 0) ? 5 : m_state - 1);
            wr  = at_edge;
        end
        if (nxt != m_state) m_prev = m_state;
        m_state = nxt;
        e.tag = tag; e.cnt = 4'(m_state); e.prev = 4'(m_prev); e.wr = wr; e.le = le;
        sb.push_back(e);
        @(negedge clock);
        @(posedge clock);
        e = sb.pop_front();
        chk({e.tag, ".count"}, count, e.cnt);
        chk({e.tag, ".prev"}, count_prev, e.prev);
        chk({e.tag, ".wrapped"}, wrapped, e.wr);
        chk({e.tag, ".load_err"}, load_err, e.le);
    endtask

    initial begin
        logic [2:0] g_tab[9];
        logic [2:0] g_last, g_exp;
        g_tab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
        reset_n = 1'b0; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = 4'd0;
        c_en = 1'b0; g_en = 1'b0;
        @(posedge clock);
        chk("reset.count", count, 5);
        chk("reset.prev", count_prev, 5);
        chk("reset.wrapped", wrapped, 0);
        chk("reset.load_err", load_err, 0);
        chk("reset.carry", carry_out, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 4'd0, "up");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 4'd0, "up_to3");

        #2 reset_n = 1'b0;
        #1;
        chk("midreset.count", count, 5);
        chk("midreset.prev", count_prev, 5);
        chk("midreset.wrapped", wrapped, 0);
        m_state = 5; m_prev = 5;
        @(posedge clock);
        reset_n = 1'b1;

        step(1'b1, 1'b1, 1'b0, 4'd0, "up_wrap");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd0, "down");
        step(1'b1, 1'b1, 1'b0, 4'd0, "flip");
        step(1'b1, 1'b1, 1'b0, 4'd0, "up_to5");
        step(1'b1, 1'b1, 1'b1, 4'd2, "load2");
        step(1'b0, 1'b1, 1'b1, 4'd9, "load9");
        step(1'b1, 1'b0, 1'b0, 4'd0, "down_wrap");
        step(1'b0, 1'b1, 1'b0, 4'd0, "hold");
        step(1'b0, 1'b1, 1'b1, 4'd5, "load_same");
        enable = 1'b0; load = 1'b0;

        #2 reset_n = 1'b0;
        @(posedge clock);
        reset_n = 1'b1;
        c_en = 1'b1;
        repeat (37) @(negedge clock);
        @(posedge clock);
        chk("cascade37.hi", hi_cnt, 3);
        chk("cascade37.lo", lo_cnt, 7);
        repeat (62) @(negedge clock);
        @(posedge clock);
        chk("cascade99.hi", hi_cnt, 9);
        chk("cascade99.lo", lo_cnt, 9);
        chk("cascade99.hi_carry", hi_carry, 1);
        chk("cascade99.hi_wrapped", hi_wr, 0);
        @(negedge clock);
        @(posedge clock);
        chk("cascade100.hi", hi_cnt, 0);
        chk("cascade100.lo", lo_cnt, 0);
        chk("cascade100.hi_wrapped", hi_wr, 1);
        chk("cascade100.lo_wrapped", lo_wr, 1);
        chk("cascade100.hi_prev", hi_prev, 9);
        chk("cascade.load_err", {lo_le, hi_le}, 0);
        c_en = 1'b0;

        chk("gray.start", g_cnt, 0);
        g_last = g_cnt;
        g_en = 1'b1;
        for (int i = 1; i < 9; i++) begin
            gq.push_back(g_tab[i]);
            @(negedge clock);
            @(posedge clock);
            g_exp = gq.pop_front();
            chk($sformatf("gray%0d.count", i), g_cnt, g_exp);
            chk($sformatf("gray%0d.onebit", i), $countones(g_cnt ^ g_last), 1);
            g_last = g_cnt;
        end
        chk("gray.prev_binary", g_prev, 7);
        chk("gray.wrapped", g_wr, 1);
        chk("gray.load_err", g_le, 0);
        chk("gray.carry", g_carry, 0);
        g_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
